// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit                                                               |
// | Instruction fetch stage: PC, req/ack memory fetch, op issue to decoder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int PC_W     = 4,
  parameter int OP_W     = 32,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [OP_W-1:0]  imem_rdata,
  output logic [OP_W-1:0]  op,
  output logic             op_valid,
  output logic [PC_W-1:0]  op_pc,
  input  logic             stall,
  input  logic             pc_we,
  input  logic [PC_W-1:0]  pc_in,
  output logic [CNT_W-1:0] retired
);

  localparam logic [0:0]      S_FETCH    = 1'b0;
  localparam logic [0:0]      S_ISSUE    = 1'b1;
  localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [OP_W-1:0]  r_op;
  logic             r_op_valid;
  logic [PC_W-1:0]  r_op_pc;
  logic [CNT_W-1:0] r_retired;
  logic             w_take;
  logic             w_consume;

  assign w_take    = (r_state == S_FETCH) & imem_ack;
  assign w_consume = (r_state == S_ISSUE) & r_op_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: if (imem_ack)  w_state_next = S_ISSUE;
      S_ISSUE: if (w_consume) w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Request is gated by reset so memory never sees a request while held in reset.
  always_comb begin
    imem_req  = rst_n & (r_state == S_FETCH);
    imem_addr = r_fetch_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= c_reset_pc;
      r_op       <= '0;
      r_op_valid <= 1'b0;
      r_op_pc    <= '0;
      r_retired  <= '0;
    end else begin
      if (w_take) begin
        r_op       <= imem_rdata;
        r_op_pc    <= r_fetch_pc;
        r_op_valid <= 1'b1;
      end
      // Jump inputs are only trusted on the consuming cycle; during stall they may be stale.
      if (w_consume) begin
        r_fetch_pc <= pc_we ? pc_in : (r_op_pc + PC_W'(1));
        r_op_valid <= 1'b0;
        if (r_retired != '1) begin
          r_retired <= r_retired + CNT_W'(1);
        end
      end
    end
  end

  assign op       = r_op;
  assign op_valid = r_op_valid;
  assign op_pc    = r_op_pc;
  assign retired  = r_retired;

endmodule
`default_nettype wire
